// File: rtl/frog_game_sequencer.sv
// Frogger game-flow controller: frog position, level, lives, game FSM,
// per-frame move rate limiting and obstacle step tick generation.
module frog_game_sequencer #(
    parameter int GRID_COLS   = 20,
    parameter int GRID_ROWS   = 15,
    parameter int START_LIVES = 3,
    parameter int MAX_LEVEL   = 9,
    parameter int BASE_PERIOD = 10,
    parameter int HOLD_FRAMES = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Frame_Tick,
    input  logic       i_Move_Left,
    input  logic       i_Move_Down,
    input  logic       i_Move_Up,
    input  logic       i_Move_Right,
    input  logic       i_Collision,
    output logic [4:0] o_Frog_Col,
    output logic [3:0] o_Frog_Row,
    output logic [3:0] o_Level,
    output logic [1:0] o_Lives,
    output logic [2:0] o_State,
    output logic       o_Step_Tick,
    output logic       o_Freeze
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, PLAY = 3'd1, DEATH = 3'd2, LEVEL_UP = 3'd3, GAME_OVER = 3'd4, WIN = 3'd5
    } state_t;

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int SW = $clog2(BASE_PERIOD + 1);
    localparam logic [4:0] START_COL = 5'(GRID_COLS / 2);
    localparam logic [3:0] START_ROW = 4'(GRID_ROWS - 1);
    localparam logic [4:0] LAST_COL  = 5'(GRID_COLS - 1);
    localparam logic [1:0] LIVES0    = 2'(START_LIVES);
    localparam logic [3:0] TOP_LEVEL = 4'(MAX_LEVEL);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    state_t        state;
    logic [3:0]    raw, prev, edges;   // {up, down, left, right}
    logic          moved;              // a move was already taken this frame
    logic [HW-1:0] hold_cnt;
    logic [SW-1:0] step_cnt;
    logic [SW-1:0] period;

    assign raw     = {i_Move_Up, i_Move_Down, i_Move_Left, i_Move_Right};
    assign edges   = raw & ~prev;
    assign o_State = state;

    always_comb begin
        if (int'(o_Level) < BASE_PERIOD - 1) period = SW'(BASE_PERIOD - int'(o_Level));
        else                                 period = SW'(1);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            o_Frog_Col  <= START_COL;
            o_Frog_Row  <= START_ROW;
            o_Level     <= 4'd0;
            o_Lives     <= LIVES0;
            o_Step_Tick <= 1'b0;
            o_Freeze    <= 1'b1;
            prev        <= 4'd0;
            moved       <= 1'b0;
            hold_cnt    <= '0;
            step_cnt    <= '0;
        end else begin
            prev        <= raw;
            o_Step_Tick <= 1'b0;
            case (state)
                IDLE: if (|edges) begin
                    state    <= PLAY;
                    o_Freeze <= 1'b0;
                end
                PLAY: begin
                    if (i_Frame_Tick && i_Collision) begin
                        state    <= DEATH;
                        o_Freeze <= 1'b1;
                        hold_cnt <= '0;
                        moved    <= 1'b0;
                        if (o_Lives != 2'd0) o_Lives <= o_Lives - 2'd1;
                    end else if (o_Frog_Row == 4'd0) begin
                        state    <= LEVEL_UP;
                        o_Freeze <= 1'b1;
                        hold_cnt <= '0;
                        moved    <= 1'b0;
                    end else begin
                        if (i_Frame_Tick) begin
                            if (step_cnt == period - SW'(1)) begin
                                o_Step_Tick <= 1'b1;
                                step_cnt    <= '0;
                            end else begin
                                step_cnt <= step_cnt + SW'(1);
                            end
                        end
                        // A frame tick opens a new move window, even on the tick cycle itself
                        if ((!moved || i_Frame_Tick) && |edges) begin
                            moved <= 1'b1;
                            if (edges[3]) begin
                                if (o_Frog_Row != 4'd0) o_Frog_Row <= o_Frog_Row - 4'd1;
                            end else if (edges[2]) begin
                                if (o_Frog_Row != START_ROW) o_Frog_Row <= o_Frog_Row + 4'd1;
                            end else if (edges[1]) begin
                                if (o_Frog_Col != 5'd0) o_Frog_Col <= o_Frog_Col - 5'd1;
                            end else begin
                                if (o_Frog_Col != LAST_COL) o_Frog_Col <= o_Frog_Col + 5'd1;
                            end
                        end else if (i_Frame_Tick) begin
                            moved <= 1'b0;
                        end
                    end
                end
                DEATH: if (i_Frame_Tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (o_Lives == 2'd0) begin
                            state <= GAME_OVER;
                        end else begin
                            state      <= PLAY;
                            o_Freeze   <= 1'b0;
                            o_Frog_Col <= START_COL;
                            o_Frog_Row <= START_ROW;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                LEVEL_UP: if (i_Frame_Tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (o_Level == TOP_LEVEL) begin
                            state <= WIN;
                        end else begin
                            state      <= PLAY;
                            o_Freeze   <= 1'b0;
                            o_Level    <= o_Level + 4'd1;
                            o_Frog_Col <= START_COL;
                            o_Frog_Row <= START_ROW;
                            step_cnt   <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                GAME_OVER, WIN: if (|edges) begin
                    state      <= IDLE;
                    o_Level    <= 4'd0;
                    o_Lives    <= LIVES0;
                    o_Frog_Col <= START_COL;
                    o_Frog_Row <= START_ROW;
                    step_cnt   <= '0;
                end
                default: begin
                    state    <= IDLE;
                    o_Freeze <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frog_game_sequencer.sv
// Bench for frog_game_sequencer: vector table, directed game scenarios and
// random play, all compared against a frame-numbered reference model.
module tb_frog_game_sequencer;
    localparam int COLS = 20, ROWS = 15, LIVES = 3, MAXL = 9, BASE = 10, HOLD = 60;
    localparam int S_IDLE = 0, S_PLAY = 1, S_DEATH = 2, S_LVL = 3, S_GO = 4, S_WIN = 5;
    localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LF = 4'b0010, RT = 4'b0001, NO = 4'b0000;

    logic clk = 1'b0, rst_n = 1'b0;
    logic frame = 1'b0, coll = 1'b0;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [4:0] col;
    logic [3:0] row, level;
    logic [1:0] lives;
    logic [2:0] state;
    logic step, freeze;

    int checks = 0, errors = 0, cyc_no = 0, step_seen = 0;

    frog_game_sequencer dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(frame),
        .i_Move_Left(left), .i_Move_Down(down), .i_Move_Up(up), .i_Move_Right(right),
        .i_Collision(coll),
        .o_Frog_Col(col), .o_Frog_Row(row), .o_Level(level), .o_Lives(lives),
        .o_State(state), .o_Step_Tick(step), .o_Freeze(freeze)
    );

    always #5 clk = ~clk;

    // Reference model: frames are numbered, one move allowed per frame number
    int m_state, m_col, m_row, m_level, m_lives, m_frames, m_hold, m_frame_no, m_last_mv;
    int m_step;
    logic [3:0] m_prev;

    task automatic model_reset();
        m_state = S_IDLE; m_col = COLS / 2; m_row = ROWS - 1; m_level = 0; m_lives = LIVES;
        m_frames = 0; m_hold = 0; m_frame_no = 0; m_last_mv = -1; m_step = 0; m_prev = 4'd0;
    endtask

    task automatic model_cycle(input logic [3:0] mv, input logic ft, input logic co);
        logic [3:0] e;
        int p;
        e = mv & ~m_prev;
        m_prev = mv;
        m_step = 0;
        if (ft) m_frame_no++;
        case (m_state)
            S_IDLE: if (e != 0) m_state = S_PLAY;
            S_PLAY: begin
                if (ft && co) begin
                    m_state = S_DEATH; m_hold = 0; m_last_mv = -1;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                end else if (m_row == 0) begin
                    m_state = S_LVL; m_hold = 0; m_last_mv = -1;
                end else begin
                    if (ft) begin
                        p = BASE - m_level;
                        if (p < 1) p = 1;
                        m_frames++;
                        if (m_frames == p) begin m_step = 1; m_frames = 0; end
                    end
                    if (e != 0 && m_last_mv != m_frame_no) begin
                        m_last_mv = m_frame_no;
                        if (e[3])      m_row = (m_row > 0) ? m_row - 1 : 0;
                        else if (e[2]) m_row = (m_row < ROWS - 1) ? m_row + 1 : ROWS - 1;
                        else if (e[1]) m_col = (m_col > 0) ? m_col - 1 : 0;
                        else           m_col = (m_col < COLS - 1) ? m_col + 1 : COLS - 1;
                    end
                end
            end
            S_DEATH: if (ft) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_hold = 0;
                    if (m_lives == 0) m_state = S_GO;
                    else begin m_state = S_PLAY; m_col = COLS / 2; m_row = ROWS - 1; end
                end
            end
            S_LVL: if (ft) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_hold = 0;
                    if (m_level == MAXL) m_state = S_WIN;
                    else begin
                        m_state = S_PLAY; m_level++; m_frames = 0;
                        m_col = COLS / 2; m_row = ROWS - 1;
                    end
                end
            end
            default: if (e != 0) begin
                m_state = S_IDLE; m_level = 0; m_lives = LIVES; m_frames = 0;
                m_col = COLS / 2; m_row = ROWS - 1;
            end
        endcase
    endtask

    task automatic check_model();
        checks++;
        if (int'(state) != m_state || int'(col) != m_col || int'(row) != m_row ||
            int'(level) != m_level || int'(lives) != m_lives || int'(step) != m_step ||
            freeze !== (m_state != S_PLAY)) begin
            errors++;
            $display("FAIL model cyc=%0d got st=%0d col=%0d row=%0d lvl=%0d lives=%0d step=%0b frz=%0b want st=%0d col=%0d row=%0d lvl=%0d lives=%0d step=%0d frz=%0b",
                     cyc_no, state, col, row, level, lives, step, freeze,
                     m_state, m_col, m_row, m_level, m_lives, m_step, m_state != S_PLAY);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc_no, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] mv, input logic ft, input logic co);
        {up, down, left, right} = mv;
        frame = ft;
        coll  = co;
        @(posedge clk);
        model_cycle(mv, ft, co);
        cyc_no++;
        #1;
        if (step) step_seen++;
        check_model();
    endtask

    task automatic tick_frames(input int n);
        for (int i = 0; i < n; i++) begin cyc(NO, 1'b1, 1'b0); cyc(NO, 1'b0, 1'b0); end
    endtask

    task automatic mv_frame(input logic [3:0] m);
        cyc(m, 1'b1, 1'b0);
        cyc(NO, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [3:0] mv; logic ft; logic co;
        int st; int c; int r; int li; logic frz; logic stp;
    } vec_t;
    vec_t vt[10];

    initial begin
        vt[0] = '{NO,      0, 0, S_IDLE,  10, 14, 3, 1, 0};
        vt[1] = '{UP,      0, 0, S_PLAY,  10, 14, 3, 0, 0};
        vt[2] = '{NO,      0, 0, S_PLAY,  10, 14, 3, 0, 0};
        vt[3] = '{UP,      0, 0, S_PLAY,  10, 13, 3, 0, 0};
        vt[4] = '{LF,      0, 0, S_PLAY,  10, 13, 3, 0, 0};
        vt[5] = '{NO,      1, 0, S_PLAY,  10, 13, 3, 0, 0};
        vt[6] = '{UP | LF, 0, 0, S_PLAY,  10, 12, 3, 0, 0};
        vt[7] = '{NO,      1, 1, S_DEATH, 10, 12, 2, 1, 0};
        vt[8] = '{UP,      0, 0, S_DEATH, 10, 12, 2, 1, 0};
        vt[9] = '{NO,      1, 0, S_DEATH, 10, 12, 2, 1, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("reset_state", int'(state), S_IDLE);
        chk("reset_freeze", int'(freeze), 1);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc(vt[i].mv, vt[i].ft, vt[i].co);
            checks++;
            if (int'(state) != vt[i].st || int'(col) != vt[i].c || int'(row) != vt[i].r ||
                int'(lives) != vt[i].li || freeze !== vt[i].frz || step !== vt[i].stp) begin
                errors++;
                $display("FAIL vec%0d got st=%0d col=%0d row=%0d lives=%0d frz=%0b step=%0b want st=%0d col=%0d row=%0d lives=%0d frz=%0b step=%0b",
                         i, state, col, row, lives, freeze, step,
                         vt[i].st, vt[i].c, vt[i].r, vt[i].li, vt[i].frz, vt[i].stp);
            end
        end

        // finish the death pause (one tick already counted)
        tick_frames(HOLD - 1);
        chk("death_return_state", int'(state), S_PLAY);
        chk("death_return_pos", int'({col, row}), int'({5'd10, 4'd14}));

        step_seen = 0;
        tick_frames(25);
        chk("steps_level0", step_seen, 2);

        mv_frame(DN);
        chk("clamp_down_row", int'(row), 14);
        for (int i = 0; i < 10; i++) mv_frame(LF);
        mv_frame(LF);
        chk("clamp_left_col", int'(col), 0);
        chk("clamp_state", int'(state), S_PLAY);

        cyc(NO, 1'b1, 1'b1);
        chk("death2_lives", int'(lives), 1);
        tick_frames(HOLD);
        cyc(NO, 1'b1, 1'b1);
        chk("death3_lives", int'(lives), 0);
        tick_frames(HOLD);
        chk("game_over", int'(state), S_GO);
        cyc(NO, 1'b1, 1'b1);
        chk("go_ignores_coll", int'(state), S_GO);
        cyc(UP, 1'b0, 1'b0);
        chk("go_exit_state", int'(state), S_IDLE);
        chk("go_exit_lives", int'(lives), LIVES);

        cyc(NO, 1'b0, 1'b0);
        cyc(UP, 1'b0, 1'b0);
        cyc(NO, 1'b0, 1'b0);
        for (int i = 0; i < ROWS - 1; i++) mv_frame(UP);
        chk("goal_level_up", int'(state), S_LVL);
        tick_frames(HOLD);
        chk("level1", int'(level), 1);
        chk("level1_row", int'(row), 14);

        // goal reached and collision within the same frame
        for (int i = 0; i < ROWS - 2; i++) mv_frame(UP);
        cyc(NO, 1'b1, 1'b0);
        cyc(NO, 1'b0, 1'b0);
        cyc(UP, 1'b0, 1'b0);
        cyc(NO, 1'b1, 1'b1);
        chk("goal_coll_state", int'(state), S_DEATH);
        tick_frames(HOLD);

        for (int l = 1; l < MAXL; l++) begin
            for (int i = 0; i < ROWS - 1; i++) mv_frame(UP);
            tick_frames(HOLD);
        end
        chk("level9", int'(level), MAXL);
        step_seen = 0;
        tick_frames(5);
        chk("steps_level9", step_seen, 5);
        for (int i = 0; i < ROWS - 1; i++) mv_frame(UP);
        tick_frames(HOLD);
        chk("win_state", int'(state), S_WIN);

        cyc(UP, 1'b0, 1'b0);
        cyc(NO, 1'b0, 1'b0);
        cyc(UP, 1'b0, 1'b0);
        cyc(NO, 1'b1, 1'b1);
        tick_frames(3);
        chk("pre_reset_state", int'(state), S_DEATH);
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", int'(state), S_IDLE);
        chk("async_reset_lives", int'(lives), LIVES);
        chk("async_reset_pos", int'({col, row}), int'({5'd10, 4'd14}));
        chk("async_reset_freeze", int'(freeze), 1);
        model_reset();
        up = 1'b0; frame = 1'b0; coll = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            logic [3:0] mv;
            logic ft, co;
            mv = {up, down, left, right};
            if ($urandom_range(0, 2) == 0) mv[3] = ~mv[3];
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) mv[b] = ~mv[b];
            ft = ($urandom_range(0, 2) == 0);
            co = ft && ($urandom_range(0, 24) == 0);
            cyc(mv, ft, co);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
